// File: rtl/segmentation_pkg.sv
// Shared types and constants for the segmentation unit: selector codes, fault codes,
// access sizes and the descriptor cache entry layout.
package segmentation_pkg;

  localparam int NUM_SEGMENTS = 6;

  typedef enum logic [2:0] {
    ES = 3'd0,
    CS = 3'd1,
    SS = 3'd2,
    DS = 3'd3,
    FS = 3'd4,
    GS = 3'd5
  } segment_t;

  typedef enum logic [1:0] {
    FAULT_NONE          = 2'd0,
    FAULT_LIMIT         = 2'd1,
    FAULT_NOT_PRESENT   = 2'd2,
    FAULT_WRITE_PROTECT = 2'd3
  } fault_code_t;

  typedef enum logic [1:0] {
    SIZE_BYTE      = 2'd0,
    SIZE_WORD      = 2'd1,
    SIZE_DWORD     = 2'd2,
    SIZE_DWORD_ALT = 2'd3
  } access_size_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } unit_state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [19:0] limit;
    logic        granularity;
    logic        writable;
    logic        present;
  } descriptor_t;

  // Flat 4 GiB, writable, present.
  localparam descriptor_t DESCRIPTOR_RESET = '{
    base:        32'h0000_0000,
    limit:       20'hF_FFFF,
    granularity: 1'b1,
    writable:    1'b1,
    present:     1'b1
  };

  // Stand-in for selector codes beyond the cache, so they fail the present check.
  localparam descriptor_t DESCRIPTOR_ABSENT = '{
    base:        32'h0000_0000,
    limit:       20'h0_0000,
    granularity: 1'b0,
    writable:    1'b0,
    present:     1'b0
  };

  function automatic logic [2:0] access_bytes(input access_size_t size);
    logic [2:0] bytes;
    case (size)
      SIZE_BYTE:  bytes = 3'd1;
      SIZE_WORD:  bytes = 3'd2;
      default:    bytes = 3'd4;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/segment_limit_checker.sv
// Combinational protection check for one request against one descriptor:
// present, then write protect, then limit.
module segment_limit_checker
  import segmentation_pkg::*;
(
  input  descriptor_t  descriptor,
  input  logic [31:0]  effective_address,
  input  access_size_t access_size,
  input  logic         write,
  output fault_code_t  fault_code
);

  logic [31:0] effective_limit_s;
  logic [32:0] last_byte_s;
  logic        unused_base_s;

  assign unused_base_s = ^descriptor.base;

  // Effective limit expansion and 33-bit address of the last byte touched.
  always_comb begin
    if (descriptor.granularity) begin
      effective_limit_s = {descriptor.limit, 12'hFFF};
    end else begin
      effective_limit_s = {12'h000, descriptor.limit};
    end
    last_byte_s = {1'b0, effective_address} + {30'd0, access_bytes(access_size)} - 33'd1;
  end

  // Fault selection in priority order.
  always_comb begin
    fault_code = FAULT_NONE;
    if (!descriptor.present) begin
      fault_code = FAULT_NOT_PRESENT;
    end else if (write && !descriptor.writable) begin
      fault_code = FAULT_WRITE_PROTECT;
    end else if (last_byte_s[32] || (last_byte_s[31:0] > effective_limit_s)) begin
      fault_code = FAULT_LIMIT;
    end else begin
      fault_code = FAULT_NONE;
    end
  end

endmodule

// File: rtl/segmentation_unit.sv
// Segment-relative to linear address translation with a six-entry descriptor cache,
// valid/ready on both sides and one-cycle fault pulses instead of forwarded requests.
module segmentation_unit
  import segmentation_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load_valid,
  input  logic [2:0]  i_load_segment,
  input  logic [31:0] i_load_base,
  input  logic [19:0] i_load_limit,
  input  logic        i_load_granularity,
  input  logic        i_load_writable,
  input  logic        i_load_present,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_segment,
  input  logic [31:0] i_effective_address,
  input  logic [1:0]  i_access_size,
  input  logic        i_write,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_linear_address,
  output logic        o_write,
  output logic        o_fault,
  output logic [1:0]  o_fault_code,
  output logic [2:0]  o_fault_segment
);

  descriptor_t descriptor_r [NUM_SEGMENTS];
  descriptor_t selected_s;
  fault_code_t check_code_s;
  unit_state_t state_r;
  unit_state_t next_state_s;

  logic        valid_d_s;
  logic [31:0] linear_d_s;
  logic        write_d_s;
  logic        fault_d_s;
  fault_code_t fault_code_d_s;
  logic [2:0]  fault_segment_d_s;
  logic        load_in_range_s;
  logic        request_in_range_s;

  assign load_in_range_s    = ({29'd0, i_load_segment} < 32'(NUM_SEGMENTS));
  assign request_in_range_s = ({29'd0, i_segment} < 32'(NUM_SEGMENTS));
  assign o_ready            = (state_r == ST_IDLE);

  // Descriptor cache; writes land on the edge so a same-cycle request sees old contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEGMENTS; i++) begin
        descriptor_r[i] <= DESCRIPTOR_RESET;
      end
    end else if (i_load_valid && load_in_range_s) begin
      descriptor_r[i_load_segment] <= '{
        base:        i_load_base,
        limit:       i_load_limit,
        granularity: i_load_granularity,
        writable:    i_load_writable,
        present:     i_load_present
      };
    end
  end

  // Descriptor lookup for the incoming request.
  always_comb begin
    selected_s = DESCRIPTOR_ABSENT;
    if (request_in_range_s) begin
      selected_s = descriptor_r[i_segment];
    end else begin
      selected_s = DESCRIPTOR_ABSENT;
    end
  end

  segment_limit_checker u_checker (
    .descriptor        (selected_s),
    .effective_address (i_effective_address),
    .access_size       (access_size_t'(i_access_size)),
    .write             (i_write),
    .fault_code        (check_code_s)
  );

  // Next state and next output values.
  always_comb begin
    next_state_s      = state_r;
    valid_d_s         = o_valid;
    linear_d_s        = o_linear_address;
    write_d_s         = o_write;
    fault_d_s         = 1'b0;
    fault_code_d_s    = FAULT_NONE;
    fault_segment_d_s = 3'd0;
    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          if (check_code_s == FAULT_NONE) begin
            next_state_s = ST_HOLD;
            valid_d_s    = 1'b1;
            linear_d_s   = selected_s.base + i_effective_address;
            write_d_s    = i_write;
          end else begin
            next_state_s      = ST_IDLE;
            fault_d_s         = 1'b1;
            fault_code_d_s    = check_code_s;
            fault_segment_d_s = i_segment;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (i_ready) begin
          next_state_s = ST_IDLE;
          valid_d_s    = 1'b0;
        end else begin
          next_state_s = ST_HOLD;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        valid_d_s    = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs to the paging unit and fault reporting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid          <= 1'b0;
      o_linear_address <= 32'h0000_0000;
      o_write          <= 1'b0;
      o_fault          <= 1'b0;
      o_fault_code     <= 2'd0;
      o_fault_segment  <= 3'd0;
    end else begin
      o_valid          <= valid_d_s;
      o_linear_address <= linear_d_s;
      o_write          <= write_d_s;
      o_fault          <= fault_d_s;
      o_fault_code     <= fault_code_d_s;
      o_fault_segment  <= fault_segment_d_s;
    end
  end

endmodule
